// File: rtl/mac_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mac_ctrl_pkg
// Shared types and constants for the mac_array sequencer.
//   state_e   : sequencer states (IDLE, LOAD, GAP, EXEC, DRAIN, DONE)
//   INST_*    : inst_w encodings understood by mac_array
// ---------------------------------------------------------------------------
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GAP   = 3'd2,
        S_EXEC  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_ctrl_cnt.sv
// ---------------------------------------------------------------------------
// mac_ctrl_cnt
// Up-counter with synchronous clear, enable and saturation at all-ones.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear to zero (wins over i_en)
//   i_en           : count up by one, holding at the maximum value
//   o_cnt          : current count
// ---------------------------------------------------------------------------
module mac_ctrl_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mac_array_ctrl.sv
// ---------------------------------------------------------------------------
// mac_array_ctrl
// Runs one mac_array tile per accepted start: ROW weight loads from L0, one
// idle gap, exec_len activation vectors, then waits for the partial sums to
// drain (counted on valid[COL-1]) or for a drain timeout.
//   i_clk, i_reset : clock, asynchronous active-low reset
//   i_start        : tile request, only looked at in IDLE
//   i_exec_len     : number of execute vectors, latched with i_start
//   i_l0_empty     : L0 has nothing to give this cycle
//   o_l0_rd        : L0 read strobe (data arrives one cycle later)
//   i_valid        : mac_array column-valid vector
//   o_inst_w       : registered instruction, lined up with the L0 data beat
//   o_busy         : not IDLE
//   o_done         : one-cycle completion pulse
//   o_err          : sticky drain timeout, cleared by the next start
// ---------------------------------------------------------------------------
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int LEN_BW = 8,
    parameter int TO_BW  = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [LEN_BW-1:0] i_exec_len,
    input  logic              i_l0_empty,
    output logic              o_l0_rd,
    input  logic [COL-1:0]    i_valid,
    output logic [1:0]        o_inst_w,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int TO_LIM = 2 * (ROW + COL);

    state_e            r_state;
    state_e            w_next;
    logic [LEN_BW-1:0] r_exec_len;
    logic [1:0]        r_inst_w;
    logic              r_err;

    logic [LEN_BW-1:0] w_ld_cnt;
    logic [LEN_BW-1:0] w_ex_cnt;
    logic [LEN_BW-1:0] w_vcnt;
    logic [TO_BW-1:0]  w_to_cnt;
    logic [LEN_BW:0]   w_ex_nxt;
    logic [LEN_BW:0]   w_vcnt_nxt;

    logic w_start_acc;
    logic w_rd_ld;
    logic w_rd_ex;
    logic w_beat;
    logic w_ld_last;
    logic w_ex_last;
    logic w_vc_hit;
    logic w_timeout;
    logic w_to_clr;
    logic w_unused_valid;

    // Only the last column tells us a partial sum has left the array.
    assign w_unused_valid = ^i_valid[COL-2:0];

    assign w_start_acc = (r_state == S_IDLE) && i_start;
    assign w_rd_ld     = (r_state == S_LOAD) && !i_l0_empty;
    assign w_rd_ex     = (r_state == S_EXEC) && !i_l0_empty;
    // Tail beats can already come out while we are still executing.
    assign w_beat      = i_valid[COL-1] && ((r_state == S_EXEC) || (r_state == S_DRAIN));

    // One bit wider so exec_len = 2^LEN_BW-1 compares without wrapping.
    assign w_ex_nxt    = {1'b0, w_ex_cnt} + 1'b1;
    assign w_vcnt_nxt  = {1'b0, w_vcnt} + 1'b1;

    assign w_ld_last   = w_rd_ld && (w_ld_cnt == LEN_BW'(ROW - 1));
    assign w_ex_last   = w_rd_ex && (w_ex_nxt == {1'b0, r_exec_len});

    // Finish in the cycle the last beat is seen, so done follows it directly.
    assign w_vc_hit    = (w_vcnt == r_exec_len) ||
                         (w_beat && (w_vcnt_nxt == {1'b0, r_exec_len}));
    // Fires on the TO_LIM-th consecutive beat-free DRAIN cycle; a beat in that
    // same cycle keeps it from firing.
    assign w_timeout   = (r_state == S_DRAIN) && !w_beat &&
                         (w_to_cnt == TO_BW'(TO_LIM - 1));

    assign w_to_clr    = w_beat || ((w_next == S_DRAIN) && (r_state != S_DRAIN));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start)   w_next = S_LOAD;
            S_LOAD:  if (w_ld_last) w_next = S_GAP;
            S_GAP:   w_next = (r_exec_len == '0) ? S_DRAIN : S_EXEC;
            S_EXEC:  if (w_ex_last) w_next = S_DRAIN;
            S_DRAIN: if (w_vc_hit || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_l0_rd = w_rd_ld || w_rd_ex;
        o_busy  = (r_state != S_IDLE);
        o_done  = (r_state == S_DONE);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_exec_len <= '0;
            r_inst_w   <= INST_IDLE;
            r_err      <= 1'b0;
        end else begin
            if (w_start_acc)
                r_exec_len <= i_exec_len;

            if (w_rd_ld)
                r_inst_w <= INST_LOAD;
            else if (w_rd_ex)
                r_inst_w <= INST_EXEC;
            else
                r_inst_w <= INST_IDLE;

            if (w_start_acc)
                r_err <= 1'b0;
            else if (w_timeout && !w_vc_hit)
                r_err <= 1'b1;
        end
    end

    assign o_inst_w = r_inst_w;
    assign o_err    = r_err;

    // ---------------- counters ----------------
    mac_ctrl_cnt #(.W(LEN_BW)) u_ld_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_clr   (w_start_acc),
        .i_en    (w_rd_ld),
        .o_cnt   (w_ld_cnt)
    );

    mac_ctrl_cnt #(.W(LEN_BW)) u_ex_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_clr   (w_start_acc),
        .i_en    (w_rd_ex),
        .o_cnt   (w_ex_cnt)
    );

    mac_ctrl_cnt #(.W(LEN_BW)) u_vcnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_clr   (w_start_acc),
        .i_en    (w_beat),
        .o_cnt   (w_vcnt)
    );

    mac_ctrl_cnt #(.W(TO_BW)) u_to_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .i_clr   (w_to_clr),
        .i_en    (r_state == S_DRAIN),
        .o_cnt   (w_to_cnt)
    );

endmodule

// File: tb/tb_mac_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_array_ctrl
// Directed and randomised tiles. For each tile the bench decides the L0-empty
// pattern and the valid[7] beats up front, then works out from the sequencing
// rules which cycles read L0, what inst_w shows, when done pulses and whether
// the drain times out, and compares the DUT cycle by cycle.
// Cycle c of a tile is the clock period after the c-th rising edge counted
// from the edge where start is driven (c = 0).
// ---------------------------------------------------------------------------
module tb_mac_array_ctrl;

    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int TO_LIM = 2 * (ROW + COL);
    localparam int MAXC   = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] exec_len;
    logic       l0_empty;
    logic [7:0] valid;
    logic       l0_rd;
    logic [1:0] inst_w;
    logic       busy;
    logic       done;
    logic       err;

    mac_array_ctrl #(.ROW(ROW), .COL(COL), .LEN_BW(8), .TO_BW(6)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_exec_len (exec_len),
        .i_l0_empty (l0_empty),
        .o_l0_rd    (l0_rd),
        .i_valid    (valid),
        .o_inst_w   (inst_w),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // stimulus and expectations for one tile
    bit         emp    [MAXC];
    logic [7:0] vld    [MAXC];
    bit         exp_rd [MAXC];
    logic [1:0] exp_iw [MAXC];
    int  t_len, t_gap, t_done, t_ex3;
    bit  t_err, prev_err;
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic fill_emp(input int pct);
        for (int i = 0; i < MAXC; i++) emp[i] = ($urandom_range(99) < pct);
    endtask

    // Derive the tile's expected behaviour from the rules:
    // reads take the first non-empty cycles, ROW loads, one gap cycle, then
    // len executes; each read shows up on inst_w one cycle later; beats from
    // the first execute cycle on are counted; done follows the final beat or
    // TO_LIM beat-free drain cycles.
    task automatic build(input int len, input int short_n, input int beat_pct);
        int c, n, d, b, cnt, idle;
        t_len = len; t_err = 0; t_done = -1; t_ex3 = -1;
        for (int i = 0; i < MAXC; i++) begin
            exp_rd[i] = 0;
            exp_iw[i] = 2'b00;
            vld[i]    = 8'($urandom) & 8'h7f;
        end
        c = 1; n = 0;
        while (n < ROW) begin
            if (!emp[c]) begin exp_rd[c] = 1; exp_iw[c+1] = 2'b01; n++; end
            c++;
        end
        t_gap = c;
        // beats before execute starts must be ignored
        for (int i = 1; i <= t_gap; i++) if ($urandom_range(9) == 0) vld[i][7] = 1'b1;
        c = t_gap + 1; n = 0;
        while (n < len) begin
            if (!emp[c]) begin
                exp_rd[c] = 1; exp_iw[c+1] = 2'b10; n++;
                if (n == 3) t_ex3 = c;
            end
            c++;
        end
        d = c;
        b = 0; c = t_gap + 2;
        while (b < len - short_n && c < MAXC - 60) begin
            if ($urandom_range(99) < beat_pct) begin vld[c][7] = 1'b1; b++; end
            c++;
        end
        cnt = 0;
        for (int i = t_gap + 1; i < d; i++) cnt += int'(vld[i][7]);
        idle = 0;
        for (int i = d; i < MAXC - 4 && t_done < 0; i++) begin
            if (cnt == len || (vld[i][7] && cnt + 1 == len)) t_done = i + 1;
            else if (vld[i][7]) begin cnt++; idle = 0; end
            else begin
                idle++;
                if (idle == TO_LIM) begin t_done = i + 1; t_err = 1; end
            end
        end
    endtask

    task automatic run(input int abort_at, input int extra_start, input bit noise);
        int last, obs_rd, obs_done;
        obs_rd = 0; obs_done = 0;
        last = (abort_at >= 0) ? abort_at : t_done + 2;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            start    = (c == 0) || (c == extra_start) ||
                       (noise && c >= 1 && c <= t_done && $urandom_range(5) == 0);
            exec_len = (c == 0) ? 8'(t_len) : 8'($urandom);
            l0_empty = emp[c];
            valid    = vld[c];
            if (c == abort_at) begin
                #1 reset = 1'b0;
                #3;
                chk("abort_rd",   c, l0_rd,  0);
                chk("abort_inst", c, inst_w, 0);
                chk("abort_busy", c, busy,   0);
                chk("abort_done", c, done,   0);
                chk("abort_err",  c, err,    0);
            end else begin
                #4;
                chk("l0_rd",  c, l0_rd,  exp_rd[c]);
                chk("inst_w", c, inst_w, exp_iw[c]);
                chk("busy",   c, busy,   (c >= 1 && c <= t_done));
                chk("done",   c, done,   (c == t_done));
                chk("err",    c, err,    (c == 0) ? prev_err : ((c >= t_done) ? t_err : 1'b0));
                obs_rd   += int'(l0_rd);
                obs_done += int'(done);
            end
        end
        start = 1'b0;
        if (abort_at < 0) begin
            chk("rd_total", last, obs_rd, ROW + t_len);
            chk("done_cnt", last, obs_done, 1);
            prev_err = t_err;
        end
    endtask

    // hold reset a few cycles after an abort, then come back out of it
    task automatic abort_tail();
        l0_empty = 1'b0; valid = 8'h80;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 3) reset = 1'b1;
            #4;
            chk("post_rst_busy", c, busy,   0);
            chk("post_rst_done", c, done,   0);
            chk("post_rst_inst", c, inst_w, 0);
        end
        valid = 8'h00;
        prev_err = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; exec_len = 8'd0; l0_empty = 1'b0; valid = 8'h00;
        prev_err = 0;
        repeat (2) @(posedge clk);
        #5;
        chk("rst_rd",   0, l0_rd,  0);
        chk("rst_inst", 0, inst_w, 0);
        chk("rst_busy", 0, busy,   0);
        chk("rst_done", 0, done,   0);
        chk("rst_err",  0, err,    0);
        @(posedge clk); #1 reset = 1'b1;

        // nominal tile
        fill_emp(0); build(8, 0, 60); run(-1, -1, 0);

        // stalls: 3 cycles mid-LOAD, 2 cycles mid-EXEC (exec starts at 13)
        fill_emp(0);
        emp[4] = 1; emp[5] = 1; emp[6] = 1; emp[15] = 1; emp[16] = 1;
        build(8, 0, 60); run(-1, -1, 0);

        // no execute vectors
        fill_emp(0); build(0, 0, 60); run(-1, -1, 0);

        // timeout: one beat short, then a tile that must clear err
        fill_emp(0); build(4, 1, 60); run(-1, -1, 0);
        fill_emp(0); build(5, 0, 70); run(-1, -1, 0);

        // reset on the third execute beat, then a clean tile
        fill_emp(0); build(8, 0, 60); run(t_ex3, -1, 0); abort_tail();
        fill_emp(0); build(8, 0, 60); run(-1, -1, 0);

        // start during EXEC is ignored
        fill_emp(0); build(8, 0, 60); run(-1, t_gap + 3, 0);

        // largest exec_len
        fill_emp(0); build(255, 0, 100); run(-1, -1, 0);

        // randomised tiles
        for (int k = 0; k < 12; k++) begin
            int len, sh;
            len = int'($urandom_range(20));
            sh  = (len > 0 && $urandom_range(3) == 0) ? 1 : 0;
            fill_emp(int'($urandom_range(40)));
            build(len, sh, int'($urandom_range(90, 30)));
            run(-1, -1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
